// File: rtl/mem_responder.sv
// Main-memory responder for the cache's mem interface: a word array behind a fixed
// access latency, with a one-cycle mem_rdy completion pulse for reads and writes.
module mem_responder #(
  parameter int DATA_WIDTH     = 32,
  parameter int ADDR_WIDTH     = 32,
  parameter int MEM_WORDS      = 1024,
  parameter int WORD_ADDR_BITS = 10,
  parameter int LATENCY        = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  mem_ren,
  input  logic                  mem_wen,
  input  logic [ADDR_WIDTH-1:0] mem_addr,
  input  logic [DATA_WIDTH-1:0] mem_din,
  output logic [DATA_WIDTH-1:0] mem_dout,
  output logic                  mem_rdy
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    RESP = 2'd2
  } state_t;

  localparam int CNT_W = $clog2(LATENCY + 1);
  localparam logic [CNT_W-1:0] CNT_ZERO = {CNT_W{1'b0}};
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(LATENCY - 1);

  state_t                    state_r, state_s;
  logic [CNT_W-1:0]          cnt_r, cnt_s;
  logic                      op_wr_r, op_wr_s;
  logic [WORD_ADDR_BITS-1:0] idx_r, idx_s;
  logic [DATA_WIDTH-1:0]     din_r, din_s;
  logic                      enter_resp_s;
  logic [DATA_WIDTH-1:0]     mem_r [MEM_WORDS];

  // Address bits outside the word index are deliberately dropped (alignment and aliasing).
  logic unused_addr_s;
  assign unused_addr_s = ^{mem_addr[ADDR_WIDTH-1:WORD_ADDR_BITS+2], mem_addr[1:0]};

  // Next-state logic; the commit in the RESP-entry cycle uses the *_s view so LATENCY=1 works.
  always_comb begin
    state_s      = state_r;
    cnt_s        = cnt_r;
    op_wr_s      = op_wr_r;
    idx_s        = idx_r;
    din_s        = din_r;
    enter_resp_s = 1'b0;
    case (state_r)
      IDLE: begin
        if (mem_ren || mem_wen) begin
          op_wr_s = mem_wen;
          idx_s   = mem_addr[WORD_ADDR_BITS+1:2];
          din_s   = mem_din;
          if (LATENCY == 1) begin
            state_s      = RESP;
            cnt_s        = CNT_ZERO;
            enter_resp_s = 1'b1;
          end else begin
            state_s = BUSY;
            cnt_s   = CNT_LOAD;
          end
        end else begin
          state_s = IDLE;
        end
      end
      BUSY: begin
        if (cnt_r <= CNT_ONE) begin
          state_s      = RESP;
          cnt_s        = CNT_ZERO;
          enter_resp_s = 1'b1;
        end else begin
          cnt_s = cnt_r - CNT_ONE;
        end
      end
      RESP: begin
        state_s = IDLE;
      end
      default: begin
        state_s = IDLE;
        cnt_s   = CNT_ZERO;
      end
    endcase
  end

  // FSM and request-latch registers; mem_rdy is the registered RESP-entry strobe.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r <= IDLE;
      cnt_r   <= CNT_ZERO;
      op_wr_r <= 1'b0;
      idx_r   <= {WORD_ADDR_BITS{1'b0}};
      din_r   <= {DATA_WIDTH{1'b0}};
      mem_rdy <= 1'b0;
    end else begin
      state_r <= state_s;
      cnt_r   <= cnt_s;
      op_wr_r <= op_wr_s;
      idx_r   <= idx_s;
      din_r   <= din_s;
      mem_rdy <= enter_resp_s;
    end
  end

  // Memory array and read-data register; reads and writes both land on RESP entry.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < MEM_WORDS; i++) begin
        mem_r[i] <= {DATA_WIDTH{1'b0}};
      end
      mem_dout <= {DATA_WIDTH{1'b0}};
    end else begin
      if (enter_resp_s && op_wr_s) begin
        mem_r[idx_s] <= din_s;
      end
      if (enter_resp_s && !op_wr_s) begin
        mem_dout <= mem_r[idx_s];
      end
    end
  end

endmodule

// File: tb/tb_mem_responder.sv
// Randomized and directed bench for mem_responder against a transaction-level memory
// model: each accepted request completes LAT cycles after the cycle it was presented in.
module tb_mem_responder;
  localparam int DW = 32, AW = 32, WORDS = 1024, WAB = 10, LAT = 4;

  logic          clk = 1'b0;
  logic          rst, mem_ren, mem_wen, mem_rdy;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_din, mem_dout;

  mem_responder #(
    .DATA_WIDTH(DW), .ADDR_WIDTH(AW), .MEM_WORDS(WORDS),
    .WORD_ADDR_BITS(WAB), .LATENCY(LAT)
  ) dut (
    .clk(clk), .rst(rst), .mem_ren(mem_ren), .mem_wen(mem_wen),
    .mem_addr(mem_addr), .mem_din(mem_din), .mem_dout(mem_dout), .mem_rdy(mem_rdy)
  );

  always #5 clk = ~clk;

  int n_checks = 0, n_fail = 0;
  logic [DW-1:0] ref_mem [WORDS];
  logic [DW-1:0] ref_dout, pend_din;
  bit  pend, pend_wr;
  int  pend_cycle, pend_idx, free_at, cyc, last_rdy, last_acc, pulses;

  task automatic check_eq(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  task automatic model_clear();
    for (int i = 0; i < WORDS; i++) ref_mem[i] = '0;
    ref_dout = '0;
    pend     = 1'b0;
  endtask

  // One clock cycle: check outputs against the model, then present the given inputs.
  task automatic step(input bit r, input bit re, input bit we,
                      input logic [AW-1:0] a, input logic [DW-1:0] d);
    bit exp_rdy;
    @(negedge clk);
    exp_rdy = pend && (cyc == pend_cycle);
    if (exp_rdy) begin
      if (pend_wr) ref_mem[pend_idx] = pend_din;
      else         ref_dout = ref_mem[pend_idx];
      pend = 1'b0;
    end
    check_eq("rdy", {31'b0, mem_rdy}, {31'b0, exp_rdy});
    check_eq("dout", mem_dout, ref_dout);
    if (mem_rdy) begin
      last_rdy = cyc;
      pulses++;
    end
    rst = r; mem_ren = re; mem_wen = we; mem_addr = a; mem_din = d;
    if (r) begin
      model_clear();
      free_at = cyc + 1;
    end else if ((re || we) && cyc >= free_at) begin
      pend       = 1'b1;
      pend_cycle = cyc + LAT;
      free_at    = cyc + LAT + 1;
      pend_wr    = we;
      pend_idx   = int'((a / 4) % WORDS);
      pend_din   = d;
      last_acc   = cyc;
    end
    @(posedge clk);
    cyc++;
  endtask

  task automatic idle();
    step(1'b0, 1'b0, 1'b0, $urandom, $urandom);
  endtask

  // Present one request for one cycle, then idle until it completes (bounded).
  task automatic txn(input bit re, input bit we, input logic [AW-1:0] a, input logic [DW-1:0] d);
    step(1'b0, re, we, a, d);
    for (int i = 0; i < LAT + 3 && pend; i++) idle();
    if (pend) check_eq("txn_timeout", 32'd1, 32'd0);
    check_eq("latency", 32'(last_rdy - last_acc), 32'(LAT));
  endtask

  initial begin
    rst = 1'b1; mem_ren = 1'b0; mem_wen = 1'b0; mem_addr = '0; mem_din = '0;
    repeat (2) @(posedge clk);
    model_clear();
    cyc = 0; free_at = 0; last_rdy = -1; last_acc = 0; pulses = 0;

    repeat (10) idle();
    check_eq("reset_pulses", 32'(pulses), 32'd0);
    check_eq("reset_dout", mem_dout, 32'h0);

    txn(1'b0, 1'b1, 32'h0000_0040, 32'hDEADBEEF);
    txn(1'b1, 1'b0, 32'h0000_0040, 32'h0);
    check_eq("rd_0x40", mem_dout, 32'hDEADBEEF);

    txn(1'b0, 1'b1, 32'h0000_1004, 32'h12345678);
    txn(1'b1, 1'b0, 32'h0000_0004, 32'h0);
    check_eq("alias_0x4", mem_dout, 32'h12345678);
    txn(1'b1, 1'b0, 32'h0000_0007, 32'h0);
    check_eq("align_0x7", mem_dout, 32'h12345678);

    txn(1'b0, 1'b1, 32'h0000_0100, 32'h11);
    txn(1'b1, 1'b0, 32'h0000_0100, 32'h0);
    txn(1'b1, 1'b1, 32'h0000_0080, 32'hA5A5A5A5);
    check_eq("both_dout_kept", mem_dout, 32'h11);
    txn(1'b1, 1'b0, 32'h0000_0080, 32'h0);
    check_eq("both_wrote", mem_dout, 32'hA5A5A5A5);

    // Held read with the address wandering: accepted every LAT+1 cycles.
    pulses = 0;
    for (int i = 0; i < 20; i++) step(1'b0, 1'b1, 1'b0, 32'(i * 4), 32'h0);
    check_eq("held_pulses", 32'(pulses), 32'd4);
    for (int i = 0; i < LAT + 2 && pend; i++) idle();

    // Reset two cycles into a write: no completion, memory back to zero.
    step(1'b0, 1'b0, 1'b1, 32'h0000_0010, 32'hFFFF0000);
    idle();
    pulses = 0;
    step(1'b1, 1'b0, 1'b0, 32'h0, 32'h0);
    repeat (8) idle();
    check_eq("rst_no_rdy", 32'(pulses), 32'd0);
    txn(1'b1, 1'b0, 32'h0000_0010, 32'h0);
    check_eq("rst_rd_0x10", mem_dout, 32'h0);

    // Random traffic over a small aliased window, with occasional resets.
    for (int i = 0; i < 400; i++) begin
      step($urandom_range(0, 99) == 0, $urandom_range(0, 1) == 1, $urandom_range(0, 2) == 0,
           ($urandom & 32'hF000_0000) | (32'($urandom_range(0, 15)) << 2) | 32'($urandom_range(0, 3)),
           $urandom);
    end
    for (int i = 0; i < LAT + 2; i++) idle();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
